// File: rtl/cfu_pkg.sv
// cfu_pkg: shared encodings for the CFU MAC engine.
// Ops, counter indices, FSM states and RISC-V opcode fields.
package cfu_pkg;

  typedef enum logic [2:0] {
    OP_MAC_CLR  = 3'd0,
    OP_MAC      = 3'd1,
    OP_REQUANT  = 3'd2,
    OP_ACC_READ = 3'd3,
    OP_CNT_READ = 3'd4,
    OP_CNT_CLR  = 3'd5,
    OP_CNT_EN   = 3'd6,
    OP_RSVD     = 3'd7
  } cfu_op_e;

  localparam int NUM_CNT     = 5;
  localparam int CNT_CYCLES  = 0;
  localparam int CNT_RETIRED = 1;
  localparam int CNT_NON_M   = 2;
  localparam int CNT_LDST    = 3;
  localparam int CNT_BUSY    = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    RESP    = 2'd2
  } state_e;

  localparam logic [4:0] OPC_LOAD  = 5'b00000;
  localparam logic [4:0] OPC_STORE = 5'b01000;
  localparam logic [4:0] OPC_OP    = 5'b01100;
  localparam logic [6:0] F7_MEXT   = 7'b0000001;

endpackage

// File: rtl/cfu_perf_counters.sv
// cfu_perf_counters: gateable event counter bank.
// Clear beats increment; reads see pre-edge values.
module cfu_perf_counters
  import cfu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 32
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_CNT-1:0] i_event,
  input  logic               i_clr,
  input  logic               i_en_we,
  input  logic [NUM_CNT-1:0] i_en_mask,
  input  logic [2:0]         i_rd_idx,
  output logic [NUM_CNT-1:0] o_mask,
  output logic [WIDTH-1:0]   o_rd_data
);

  logic [CNT_W-1:0]   cnt_q [NUM_CNT];
  logic [NUM_CNT-1:0] mask_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mask_q <= '1;
      for (int i = 0; i < NUM_CNT; i++) cnt_q[i] <= '0;
    end else begin
      if (i_en_we) mask_q <= i_en_mask;
      for (int i = 0; i < NUM_CNT; i++) begin
        if (i_clr)
          cnt_q[i] <= '0;
        else if (mask_q[i] && i_event[i])
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    o_rd_data = '0;
    if (i_rd_idx < 3'(NUM_CNT))
      o_rd_data = WIDTH'(cnt_q[i_rd_idx]);
  end

  assign o_mask = mask_q;

endmodule

// File: rtl/cfu_mac_engine.sv
// cfu_mac_engine: packed-SIMD MAC with requantise and perf counters.
// Valid/ready command in, valid/ready response out.
module cfu_mac_engine
  import cfu_pkg::*;
#(
  parameter int WIDTH           = 32,
  parameter int ELEM_W          = 8,
  parameter int LANES_PER_CYCLE = 1,
  parameter int QMIN            = -8,
  parameter int QMAX            = 7,
  parameter int CNT_W           = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [2:0]       i_cfu_op,
  input  logic [6:0]       i_cfu_funct7,
  input  logic [WIDTH-1:0] i_cfu_rs1,
  input  logic [WIDTH-1:0] i_cfu_rs2,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [WIDTH-1:0] o_cfu_rd,
  input  logic             i_ibus_ack,
  input  logic             i_rf_rreq,
  input  logic [31:0]      i_instruction
);

  localparam int N_LANES = WIDTH / ELEM_W;
  localparam int LW      = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam int PW      = 2 * ELEM_W;
  localparam logic [LW-1:0] LANE_LAST = LW'(N_LANES - LANES_PER_CYCLE);
  localparam logic [LW-1:0] LANE_STEP = LW'(LANES_PER_CYCLE);
  localparam logic signed [WIDTH:0] QLO = (WIDTH+1)'(QMIN);
  localparam logic signed [WIDTH:0] QHI = (WIDTH+1)'(QMAX);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rs1_q, rs2_q;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] rd_q, rd_d;
  logic [LW-1:0]    lane_q, lane_d;
  logic             accept;

  logic [NUM_CNT-1:0] ev, mask;
  logic               cnt_clr, en_we;
  logic [WIDTH-1:0]   cnt_rd;
  logic               retired;

  logic signed [ELEM_W-1:0] ea, eb;
  logic signed [PW-1:0]     prod;
  logic [WIDTH-1:0]         lane_sum;

  logic signed [WIDTH:0] rq_sum, rq_t;
  logic [WIDTH-1:0]      rq_res;

  logic unused_bits;
  assign unused_bits = ^{i_instruction[24:7], i_instruction[1:0],
                         i_cfu_funct7[6:1]};

  assign accept      = i_cmd_valid && o_cmd_ready;
  assign o_cmd_ready = i_rst_n && (state_q == IDLE);
  assign o_rsp_valid = (state_q == RESP);
  assign o_cfu_rd    = o_rsp_valid ? rd_q : '0;

  always_comb begin
    lane_sum = '0;
    ea = '0;
    eb = '0;
    prod = '0;
    for (int j = 0; j < LANES_PER_CYCLE; j++) begin
      ea = rs1_q[(int'(lane_q) + j) * ELEM_W +: ELEM_W];
      eb = rs2_q[(int'(lane_q) + j) * ELEM_W +: ELEM_W];
      prod = PW'(ea) * PW'(eb);
      lane_sum = lane_sum + WIDTH'(prod);
    end
  end

  // One extra bit keeps acc + rs1 from overflowing before the shift.
  always_comb begin
    rq_sum = $signed({acc_q[WIDTH-1], acc_q})
           + $signed({i_cfu_rs1[WIDTH-1], i_cfu_rs1});
    rq_t = rq_sum >>> i_cfu_rs2[4:0];
    if (i_cfu_funct7[0] && rq_t < 0) rq_t = '0;
    if (rq_t < QLO) rq_t = QLO;
    if (rq_t > QHI) rq_t = QHI;
    rq_res = rq_t[WIDTH-1:0];
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rd_d    = rd_q;
    lane_d  = lane_q;
    cnt_clr = 1'b0;
    en_we   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RESP;
          rd_d    = '0;
          unique case (cfu_op_e'(i_cfu_op))
            OP_MAC_CLR:  acc_d = '0;
            OP_MAC: begin
              state_d = COMPUTE;
              lane_d  = '0;
            end
            OP_REQUANT:  rd_d = rq_res;
            OP_ACC_READ: rd_d = acc_q;
            OP_CNT_READ: rd_d = cnt_rd;
            OP_CNT_CLR:  cnt_clr = 1'b1;
            OP_CNT_EN: begin
              en_we = 1'b1;
              rd_d  = WIDTH'(mask);
            end
            default: rd_d = '0;
          endcase
        end
      end
      COMPUTE: begin
        acc_d  = acc_q + lane_sum;
        lane_d = lane_q + LANE_STEP;
        if (lane_q == LANE_LAST) begin
          state_d = RESP;
          rd_d    = acc_d;
        end
      end
      RESP: begin
        if (i_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rd_q    <= '0;
      lane_q  <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rd_q    <= rd_d;
      lane_q  <= lane_d;
      if (accept) begin
        rs1_q <= i_cfu_rs1;
        rs2_q <= i_cfu_rs2;
      end
    end
  end

  assign retired = i_ibus_ack && i_rf_rreq;

  always_comb begin
    ev = '0;
    ev[CNT_CYCLES]  = 1'b1;
    ev[CNT_RETIRED] = retired;
    ev[CNT_NON_M]   = retired &&
      !(i_instruction[6:2] == OPC_OP && i_instruction[31:25] == F7_MEXT);
    ev[CNT_LDST]    = retired &&
      (i_instruction[6:2] == OPC_LOAD || i_instruction[6:2] == OPC_STORE);
    ev[CNT_BUSY]    = (state_q != IDLE);
  end

  cfu_perf_counters #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_cnt (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_event   (ev),
    .i_clr     (cnt_clr),
    .i_en_we   (en_we),
    .i_en_mask (i_cfu_rs1[NUM_CNT-1:0]),
    .i_rd_idx  (i_cfu_rs1[2:0]),
    .o_mask    (mask),
    .o_rd_data (cnt_rd)
  );

endmodule

// File: tb/tb_cfu_mac_engine.sv
// tb_cfu_mac_engine: directed vectors for the CFU MAC engine.
// Table-driven ops plus backpressure, counter and reset sequences.
module tb_cfu_mac_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [2:0]  op = '0;
  logic [6:0]  f7 = '0;
  logic [31:0] rs1 = '0, rs2 = '0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rd;
  logic        ibus_ack = 1'b0, rf_rreq = 1'b0;
  logic [31:0] instr = '0;

  logic        cmd_valid4 = 1'b0, cmd_ready4;
  logic [31:0] rs1_4 = '0, rs2_4 = '0;
  logic        rsp_valid4, rsp_ready4 = 1'b0;
  logic [31:0] rd4;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cfu_mac_engine u_dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_cmd_valid   (cmd_valid),
    .o_cmd_ready   (cmd_ready),
    .i_cfu_op      (op),
    .i_cfu_funct7  (f7),
    .i_cfu_rs1     (rs1),
    .i_cfu_rs2     (rs2),
    .o_rsp_valid   (rsp_valid),
    .i_rsp_ready   (rsp_ready),
    .o_cfu_rd      (rd),
    .i_ibus_ack    (ibus_ack),
    .i_rf_rreq     (rf_rreq),
    .i_instruction (instr)
  );

  cfu_mac_engine #(
    .ELEM_W          (4),
    .LANES_PER_CYCLE (4)
  ) u_dut4 (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_cmd_valid   (cmd_valid4),
    .o_cmd_ready   (cmd_ready4),
    .i_cfu_op      (3'd1),
    .i_cfu_funct7  (7'd0),
    .i_cfu_rs1     (rs1_4),
    .i_cfu_rs2     (rs2_4),
    .o_rsp_valid   (rsp_valid4),
    .i_rsp_ready   (rsp_ready4),
    .o_cfu_rd      (rd4),
    .i_ibus_ack    (1'b0),
    .i_rf_rreq     (1'b0),
    .i_instruction (32'd0)
  );

  typedef struct {
    logic [2:0]  op;
    logic [6:0]  f7;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] rd;
    int          lat;
  } vec_t;

  vec_t tv [18];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_cmd(input logic [2:0] o, input logic [6:0] f,
                         input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output int lat,
                         output bit ok);
    int w;
    ok = 1'b1;
    r = '0;
    lat = 0;
    op = o; f7 = f; rs1 = a; rs2 = b;
    cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    if (!cmd_ready) begin
      ok = 1'b0;
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    ibus_ack = 1'b0;
    rf_rreq = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    if (!rsp_valid) begin
      ok = 1'b0;
      return;
    end
    r = rd;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic cmd_chk(input string name, input logic [2:0] o,
                         input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r;
    int lat;
    bit ok;
    run_cmd(o, 7'd0, a, 32'd0, r, lat, ok);
    check({name, "_ok"}, 32'(ok), 32'd1);
    check(name, r, exp);
  endtask

  task automatic retire(input logic [31:0] ins);
    ibus_ack = 1'b1; rf_rreq = 1'b1; instr = ins;
    @(posedge clk); #1;
    ibus_ack = 1'b0; rf_rreq = 1'b0; instr = '0;
  endtask

  localparam logic [31:0] I_LW  = 32'h0000_2003;
  localparam logic [31:0] I_MUL = 32'h0200_0033;
  localparam logic [31:0] I_ADD = 32'h0000_0033;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int lat;
    bit ok;
    bit seen;

    tv[0]  = '{3'd0, 7'd0, 32'h0,        32'h0,        32'h0,        1};
    tv[1]  = '{3'd1, 7'd0, 32'h01020304, 32'h050607FF, 32'd34,       5};
    tv[2]  = '{3'd1, 7'd0, 32'h01020304, 32'h050607FF, 32'd68,       5};
    tv[3]  = '{3'd3, 7'd0, 32'h0,        32'h0,        32'd68,       1};
    tv[4]  = '{3'd0, 7'd0, 32'h0,        32'h0,        32'h0,        1};
    tv[5]  = '{3'd1, 7'd0, 32'h00000064, 32'h00000001, 32'd100,      5};
    tv[6]  = '{3'd2, 7'd0, 32'd28,       32'd5,        32'd4,        1};
    tv[7]  = '{3'd2, 7'd0, 32'd1000,     32'd5,        32'd7,        1};
    tv[8]  = '{3'd3, 7'd0, 32'h0,        32'h0,        32'd100,      1};
    tv[9]  = '{3'd0, 7'd0, 32'h0,        32'h0,        32'h0,        1};
    tv[10] = '{3'd2, 7'd0, 32'hFFFFFC18, 32'd5,        32'hFFFFFFF8, 1};
    tv[11] = '{3'd2, 7'd1, 32'hFFFFFC18, 32'd5,        32'h0,        1};
    tv[12] = '{3'd7, 7'd0, 32'd5,        32'd5,        32'h0,        1};
    tv[13] = '{3'd1, 7'd0, 32'h80808080, 32'h80808080, 32'h00010000, 5};
    tv[14] = '{3'd2, 7'd0, 32'h0,        32'h0,        32'd7,        1};
    tv[15] = '{3'd2, 7'd0, 32'hFFFEFFFF, 32'h0,        32'hFFFFFFFF, 1};
    tv[16] = '{3'd2, 7'd0, 32'h0,        32'd31,       32'h0,        1};
    tv[17] = '{3'd4, 7'd0, 32'd5,        32'h0,        32'h0,        1};

    #12;
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd0);
    check("rst_rd", rd, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 18; i++) begin
      run_cmd(tv[i].op, tv[i].f7, tv[i].rs1, tv[i].rs2, r, lat, ok);
      check($sformatf("vec%0d_ok", i), 32'(ok), 32'd1);
      check($sformatf("vec%0d_rd", i), r, tv[i].rd);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(tv[i].lat));
    end

    // Backpressure
    run_cmd(3'd0, 7'd0, 32'd0, 32'd0, r, lat, ok);
    op = 3'd1; rs1 = 32'h01020304; rs2 = 32'h050607FF;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    for (int c = 0; c < 10; c++) begin
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rd", rd, 32'd34);
      check("bp_ready", 32'(cmd_ready), 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("bp_done_valid", 32'(rsp_valid), 32'd0);
    check("bp_done_ready", 32'(cmd_ready), 32'd1);
    check("bp_done_rd", rd, 32'd0);

    // Counters
    cmd_chk("cclr", 3'd5, 32'd0, 32'd0);
    retire(I_LW); retire(I_LW); retire(I_LW);
    retire(I_MUL); retire(I_ADD); retire(I_ADD);
    cmd_chk("cnt_ret", 3'd4, 32'd1, 32'd6);
    cmd_chk("cnt_nonm", 3'd4, 32'd2, 32'd5);
    cmd_chk("cnt_ldst", 3'd4, 32'd3, 32'd3);
    cmd_chk("cnt_idx7", 3'd4, 32'd7, 32'd0);
    cmd_chk("cen_off", 3'd6, 32'd0, 32'h1F);
    retire(I_LW); retire(I_LW); retire(I_LW);
    cmd_chk("frz_ret", 3'd4, 32'd1, 32'd6);
    cmd_chk("frz_ldst", 3'd4, 32'd3, 32'd3);
    cmd_chk("cen_on", 3'd6, 32'h1F, 32'h0);
    retire(I_ADD);
    cmd_chk("cnt_ret7", 3'd4, 32'd1, 32'd7);
    ibus_ack = 1'b1; rf_rreq = 1'b1; instr = I_ADD;
    cmd_chk("cclr_coinc", 3'd5, 32'd0, 32'd0);
    instr = '0;
    cmd_chk("coinc_ret", 3'd4, 32'd1, 32'd0);

    // Reset during lane 2 of a MAC
    run_cmd(3'd0, 7'd0, 32'd0, 32'd0, r, lat, ok);
    op = 3'd1; rs1 = 32'h01020304; rs2 = 32'h050607FF;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mrst_valid", 32'(rsp_valid), 32'd0);
    check("mrst_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("mrst_ready_after", 32'(cmd_ready), 32'd1);
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (rsp_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("mrst_no_rsp", 32'(seen), 32'd0);
    cmd_chk("mrst_acc", 3'd3, 32'd0, 32'd0);

    // ELEM_W=4, LANES_PER_CYCLE=4 instance
    rs1_4 = 32'h0000001F; rs2_4 = 32'h00000072;
    cmd_valid4 = 1'b1;
    check("p4_ready", 32'(cmd_ready4), 32'd1);
    @(posedge clk); #1;
    cmd_valid4 = 1'b0;
    lat = 1;
    while (!rsp_valid4 && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    check("p4_valid", 32'(rsp_valid4), 32'd1);
    check("p4_lat", 32'(lat), 32'd3);
    check("p4_rd", rd4, 32'd5);
    rsp_ready4 = 1'b1;
    @(posedge clk); #1;
    rsp_ready4 = 1'b0;
    check("p4_done", 32'(rsp_valid4), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cfu_mac_engine.md
Name: cfu_mac_engine

Overview:
- Parametrised successor to the single-cycle CFU: a packed-SIMD multiply-accumulate engine with a persistent accumulator, a requantise/clamp stage and a bank of gateable performance counters.
- Sits between the CPU's custom-instruction port and its instruction-fetch/register-read strobes.
- Adds a full valid/ready command/response handshake, multi-cycle MAC with configurable lanes per cycle, ReLU, and runtime counter enable/clear.

Parameters:
- WIDTH, 32: operand/result width.
- ELEM_W, 8: packed signed element width; legal values 4 or 8. N_LANES = WIDTH/ELEM_W.
- LANES_PER_CYCLE, 1: lanes multiplied per COMPUTE cycle; must divide N_LANES.
- QMIN, -8: requantise clamp lower bound (signed).
- QMAX, 7: requantise clamp upper bound (signed).
- CNT_W, 32: performance counter width.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_cmd_valid  in  1  command valid
- o_cmd_ready  out  1  engine idle, command accepted this cycle if valid
- i_cfu_op  in  3  funct3 opcode
- i_cfu_funct7  in  7  funct7; bit0 = ReLU enable for REQUANT
- i_cfu_rs1  in  WIDTH  operand 1
- i_cfu_rs2  in  WIDTH  operand 2
- o_rsp_valid  out  1  result valid
- i_rsp_ready  in  1  CPU accepts result
- o_cfu_rd  out  WIDTH  result
- i_ibus_ack  in  1  fetch acknowledge
- i_rf_rreq  in  1  register-file read request
- i_instruction  in  32  instruction currently issuing

Behaviour:
- Reset (asynchronous, i_rst_n=0):
  - state IDLE; accumulator, all counters and the result register are 0.
  - Counter enable mask is all-ones.
  - o_rsp_valid=0, o_cmd_ready=0 while in reset; o_cmd_ready=1 from the first cycle after release.
- Reset asserted mid-operation aborts the op; no response is issued.
- FSM states:
  - IDLE: o_cmd_ready=1. Accept on i_cmd_valid&o_cmd_ready; latch op, funct7, rs1 and rs2. MAC goes to COMPUTE; all other ops compute in the accept cycle and go to RESP.
  - COMPUTE: each edge adds LANES_PER_CYCLE lane products to the accumulator. A lane index counter runs 0..N_LANES-1. After the final lane, go to RESP with result = new accumulator.
  - RESP: o_rsp_valid=1 with o_cfu_rd stable until i_rsp_ready. On the handshake edge, go to IDLE. There is no back-to-back accept in the same edge.
- Latency (rsp_valid high after accept edge):
  - MAC: N_LANES/LANES_PER_CYCLE+1 cycles.
  - Other ops: 1 cycle.
- o_cfu_rd is 0 whenever o_rsp_valid=0.
- Ops:
  - 000 MAC_CLR: acc <= 0; result 0.
  - 001 MAC: acc += sum over lanes of signed(rs1 lane) * signed(rs2 lane). Lane 0 is bits [ELEM_W-1:0]. Products are 2*ELEM_W bits, sign-extended to WIDTH; the accumulator wraps mod 2^WIDTH.
  - 010 REQUANT: t = (acc + signed rs1) at WIDTH+1 bits, then t >>> rs2[4:0] (arithmetic). If funct7[0] and t<0, t=0. Clamp to [QMIN,QMAX]; sign-extend to WIDTH. The accumulator is unchanged.
  - 011 ACC_READ: result = acc.
  - 100 CNT_READ: result = counter[rs1[2:0]] low WIDTH bits. Indices 5..7 return 0.
  - 101 CNT_CLR: all counters <= 0; result 0.
  - 110 CNT_EN: enable mask <= rs1[4:0]; result = previous mask.
  - 111 reserved: result 0, 1-cycle latency.
- Counters: each increments by 1 when its mask bit is set, and wraps at 2^CNT_W.
  - 0 cycles: every clock.
  - 1 retired: i_ibus_ack & i_rf_rreq.
  - 2 non-M-ext: retired and not (opcode[6:2]=01100 and funct7=0000001).
  - 3 load/store: retired and opcode[6:2] in {00000, 01000}.
  - 4 engine busy: state != IDLE.
- Simultaneous events:
  - CNT_CLR in the same edge as an increment: clear wins, so the value is 0.
  - CNT_READ returns the value before that edge's increment.

Decomposition:
- Shared package cfu_pkg holds:
  - op encodings (OP_MAC_CLR..OP_RSVD);
  - counter indices (CNT_CYCLES..CNT_BUSY), NUM_CNT=5;
  - FSM state enum (IDLE, COMPUTE, RESP);
  - opcode constants (OPC_LOAD=00000, OPC_STORE=01000, OPC_OP=01100, F7_MEXT=0000001).
- One sub-module, cfu_perf_counters: the counter bank with enable mask, clear and read mux. Its inputs are the event strobes and the busy flag.

Test Plan:
- MAC (ELEM_W=8, LANES_PER_CYCLE=1): MAC_CLR, then MAC with rs1=0x01020304, rs2=0x050607FF -> rsp_valid 5 cycles after accept, rd=34; a second identical MAC -> rd=68.
- REQUANT:
  - acc=100, rs1=28, rs2=5 -> rd=4.
  - rs1=1000 -> rd=7 (clamp).
  - acc=0, rs1=-1000, rs2=5 -> rd=0xFFFFFFF8 (-8).
  - Same with funct7=1 -> rd=0.
- Backpressure: hold i_rsp_ready=0 for 10 cycles after a MAC -> o_rsp_valid, o_cfu_rd stable and o_cmd_ready=0 throughout; handshake -> IDLE next cycle.
- Counters:
  - Issue 3 loads, 1 MUL and 2 ADDs as retire strobes -> counter1=6, counter2=5, counter3=3.
  - CNT_EN rs1=0 freezes all counters.
  - CNT_CLR coincident with a retire strobe -> counter1=0.
- Reset mid-COMPUTE: drop i_rst_n during lane 2 -> no response, acc=0, state IDLE, o_cmd_ready=1 one cycle after release.
- Parametrisation: ELEM_W=4, LANES_PER_CYCLE=4, rs1=0x0000001F, rs2=0x00000072 -> lanes (-1*2)+(1*7)=5, rd=5, latency 3 cycles.
